// File: rtl/dmem_store_buffer_if.sv
// Bus bundle between the processor data port, the store buffer and dmem.
//   slave  : the store buffer (takes processor requests, drives dmem)
//   master : the environment (processor + dmem)
// Signals:
//   cpu_mem_en, cpu_mem_wr_en, cpu_mem_addr[0:31], cpu_wr_data  processor request
//   cpu_rd_data, cpu_stall                                      processor response
//   dm_mem_en, dm_mem_wr_en, dm_mem_addr, dm_wr_data            dmem request
//   dm_rd_data                                                  dmem combinational read data
//   drain_req, sb_empty                                         flush control / status
interface dmem_store_buffer_if #(
  parameter int AW = 9,
  parameter int DW = 64
);
  logic          cpu_mem_en;
  logic          cpu_mem_wr_en;
  logic [0:31]   cpu_mem_addr;
  logic [0:DW-1] cpu_wr_data;
  logic [0:DW-1] cpu_rd_data;
  logic          cpu_stall;
  logic          dm_mem_en;
  logic          dm_mem_wr_en;
  logic [0:AW-1] dm_mem_addr;
  logic [0:DW-1] dm_wr_data;
  logic [0:DW-1] dm_rd_data;
  logic          drain_req;
  logic          sb_empty;

  modport slave (
    input  cpu_mem_en, cpu_mem_wr_en, cpu_mem_addr, cpu_wr_data, dm_rd_data, drain_req,
    output cpu_rd_data, cpu_stall, dm_mem_en, dm_mem_wr_en, dm_mem_addr, dm_wr_data, sb_empty
  );

  modport master (
    output cpu_mem_en, cpu_mem_wr_en, cpu_mem_addr, cpu_wr_data, dm_rd_data, drain_req,
    input  cpu_rd_data, cpu_stall, dm_mem_en, dm_mem_wr_en, dm_mem_addr, dm_wr_data, sb_empty
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the processor data port and the single-port dmem.
// Stores are queued in a circular FIFO and retired to dmem in cycles where the
// port is not used by an accepted access; loads get the port immediately.
// A load that hits a queued store is forwarded (STORE_FWD_EN defined) or
// stalled while the head retires (STORE_FWD_EN undefined, default build).
// Ports:
//   CLK    clock, all state on rising edge
//   RESET  synchronous, active-high; drops pending stores
//   bus    dmem_store_buffer_if.slave (processor request/response, dmem port,
//          drain_req flush input, sb_empty status)
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 9,
  parameter int DW    = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  dmem_store_buffer_if.slave bus
);
  localparam int             PW   = $clog2(DEPTH);
  localparam logic [PW:0]    FULL = (PW + 1)'(DEPTH);

  logic [0:AW-1] entryAddr [DEPTH];
  logic [0:DW-1] entryData [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;

  logic [0:AW-1] reqAddr;
  logic          isLoad, isStore, draining;
  logic          matchHit, retire, accept, stall;
  logic          dmEn, dmWr;
  logic [0:AW-1] dmAddr;
  logic [0:DW-1] dmWData, rdData;
`ifdef STORE_FWD_EN
  logic [0:DW-1] fwdData;
`endif

  // Only the word-address bits take part in compares.
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.cpu_mem_addr[0:31-AW];

  assign reqAddr  = bus.cpu_mem_addr[32-AW:31];
  assign isLoad   = bus.cpu_mem_en & ~bus.cpu_mem_wr_en;
  assign isStore  = bus.cpu_mem_en &  bus.cpu_mem_wr_en;
  assign draining = bus.drain_req && (count != '0);

  // Scan oldest to youngest so the last hit is the youngest matching store.
  always_comb begin
    matchHit = 1'b0;
`ifdef STORE_FWD_EN
    fwdData  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW + 1)'(k) < count) && (entryAddr[rdPtr + PW'(k)] == reqAddr)) begin
        matchHit = 1'b1;
`ifdef STORE_FWD_EN
        fwdData  = entryData[rdPtr + PW'(k)];
`endif
      end
    end
  end

  // Port arbitration. An accepted store owns its cycle, so the head only
  // retires when the port is otherwise free or a request is being refused.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    retire  = 1'b0;
    accept  = 1'b0;
    stall   = 1'b0;
    dmEn    = 1'b0;
    dmWr    = 1'b0;
    dmAddr  = '0;
    dmWData = '0;
    rdData  = '0;
    if (RESET) begin
      // outputs held at their reset values
    end else if (draining) begin
      retire = 1'b1;
      stall  = bus.cpu_mem_en;
    end else if (isLoad && !matchHit) begin
      dmEn   = 1'b1;
      dmAddr = reqAddr;
      rdData = bus.dm_rd_data;
    end else if (isLoad) begin
`ifdef STORE_FWD_EN
      rdData = fwdData;
`else
      stall  = 1'b1;
`endif
      retire = 1'b1;
    end else if (isStore && (count < FULL)) begin
      accept = 1'b1;
    end else begin
      retire = (count != '0);
      stall  = isStore;
    end
    if (retire) begin
      dmEn    = 1'b1;
      dmWr    = 1'b1;
      dmAddr  = entryAddr[rdPtr];
      dmWData = entryData[rdPtr];
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every reader in the same edge sees the pre-edge value.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (retire) rdPtr <= rdPtr + 1'b1;
      count <= count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, retire};
    end
  end

  // NOTE: entry storage has no reset; count gates validity, so clearing the
  // array would only add reset fan-out.
  always_ff @(posedge CLK) begin
    if (!RESET && accept) begin
      entryAddr[wrPtr] <= reqAddr;
      entryData[wrPtr] <= bus.cpu_wr_data;
    end
  end

  assign bus.cpu_rd_data  = rdData;
  assign bus.cpu_stall    = stall;
  assign bus.dm_mem_en    = dmEn;
  assign bus.dm_mem_wr_en = dmWr;
  assign bus.dm_mem_addr  = dmAddr;
  assign bus.dm_wr_data   = dmWData;
  assign bus.sb_empty     = (count == '0);
endmodule
